// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// opcode/funct values, ALU operation codes and next-PC source selects.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Primary opcodes (ins[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes (ins[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Next-PC source selects
  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  // An instruction is legal when its opcode is supported and, for R-type,
  // the funct field names one of the supported ALU operations.
  function automatic logic instr_legal(input logic [5:0] opc, input logic rtype_ok);
    case (opc)
      OPC_RTYPE:                                 return rtype_ok;
      OPC_J, OPC_BEQ, OPC_ADDI, OPC_LW, OPC_SW:  return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational R-type funct to ALU operation decode, with a legality flag
// so the controller can trap unsupported funct codes.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] op,
  output logic       legal
);

  // Map funct to ALU op; unknown funct reports illegal
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    op    = ALU_ADD;
    legal = 1'b1;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, bounds
// memory waits with a timeout, traps illegal instructions into a sticky HALT
// and counts retired instructions (one per PC update strobe).
module multi_cycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             Mem2Reg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [2:0]       op,
  output logic [1:0]       pc_sel,
  output logic             pc_we,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int                WAIT_W    = (MEM_TMO > 0) ? $clog2(MEM_TMO + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TMO);

  state_e            state_q;
  logic [5:0]        opcode_q;
  logic [5:0]        funct_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [2:0]        r_op;
  logic              r_legal;
  logic              is_lw;

  // Only the opcode and funct fields steer control; the register and
  // immediate fields belong to the datapath.
  logic unused_ins;
  assign unused_ins = ^ins[25:6];

  assign is_lw = (opcode_q == OPC_LW);
  assign cnt_d = cnt_q + CNT_W'(1);

  alu_op_decode u_alu_op_decode (
    .funct (funct_q),
    .op    (r_op),
    .legal (r_legal)
  );

  // State sequencing, opcode/funct latch, memory wait counter, retire count
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of the others.
    if (rst) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
      wait_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (pc_we) cnt_q <= cnt_d;
      case (state_q)
        ST_FETCH: begin
          opcode_q <= ins[31:26];
          funct_q  <= ins[5:0];
          state_q  <= ST_DECODE;
        end
        ST_DECODE: state_q <= instr_legal(opcode_q, r_legal) ? ST_EXEC : ST_HALT;
        ST_EXEC: begin
          wait_q <= '0;
          case (opcode_q)
            OPC_RTYPE, OPC_ADDI: state_q <= ST_WB;
            OPC_LW, OPC_SW:      state_q <= ST_MEM;
            default:             state_q <= ST_FETCH;  // beq, j retire here
          endcase
        end
        ST_MEM: begin
          // mem_rdy on the last allowed cycle still wins over the timeout
          if (mem_rdy) begin
            wait_q  <= '0;
            state_q <= is_lw ? ST_WB : ST_FETCH;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= ST_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_WB:   state_q <= ST_FETCH;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  // Moore control decode from state and latched opcode/funct (beq reads zero)
  always_comb begin
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    Mem2Reg  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    op       = 3'b000;
    pc_sel   = PC_SEL_SEQ;
    pc_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_EXEC: begin
        case (opcode_q)
          OPC_RTYPE: begin
            RegDst = 1'b1;
            op     = r_op;
          end
          OPC_ADDI, OPC_LW, OPC_SW: begin
            ALUSrc = 1'b1;
            op     = ALU_ADD;
          end
          OPC_BEQ: begin
            op     = ALU_SUB;
            pc_we  = 1'b1;
            pc_sel = zero ? PC_SEL_BRANCH : PC_SEL_SEQ;
          end
          OPC_J: begin
            op     = ALU_ADD;
            pc_we  = 1'b1;
            pc_sel = PC_SEL_JUMP;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ALUSrc   = 1'b1;
        op       = ALU_ADD;
        MemRead  = is_lw;
        MemWrite = !is_lw;
        pc_we    = mem_rdy && !is_lw;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        RegDst   = (opcode_q == OPC_RTYPE);
        Mem2Reg  = is_lw;
        pc_we    = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign instr_cnt = cnt_q;

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of retired-instruction counter.
REQ-002 SHALL have parameter MEM_TMO, default 15: max MEM-state wait cycles before a timeout halt.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ins  input  32  current instruction from the fetch stage; sampled in FETCH only.
REQ-006 zero  input  1  ALU zero flag from the execute stage.
REQ-007 mem_rdy  input  1  data memory done; valid only while MemRead or MemWrite is high.
REQ-008 RegDst, RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite  output  1 each  datapath controls, same meaning as the single-cycle datapath.
REQ-009 op  output  3  ALU operation: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-010 pc_sel  output  2  next-PC source: 0 PC+4, 1 branch target, 2 jump target.
REQ-011 pc_we  output  1  one-cycle PC update strobe; exactly one per retired instruction.
REQ-012 halted  output  1  sticky: illegal instruction or memory timeout.
REQ-013 instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-014 SHALL implement FSM FETCH, DECODE, EXEC, MEM, WB, HALT; outputs Moore-decoded from state plus latched opcode/funct.
REQ-015 FETCH: latch ins[31:26] and ins[5:0]; all controls 0; next DECODE.
REQ-016 DECODE: opcodes 0x00 (funct 0x20/22/24/25/2A), 0x02 j, 0x04 beq, 0x08 addi, 0x23 lw, 0x2B sw legal -> EXEC; any other opcode/funct -> HALT.
REQ-017 EXEC R-type: RegDst=1, ALUSrc=0, op from funct (add 010, sub 110, and 000, or 001, slt 111); next WB.
REQ-018 EXEC addi/lw/sw: ALUSrc=1, op=010; addi -> WB, lw/sw -> MEM.
REQ-019 EXEC beq: ALUSrc=0, op=110, pc_we=1, pc_sel=1 if zero else 0; next FETCH.
REQ-020 EXEC j: pc_we=1, pc_sel=2, op=010; next FETCH.
REQ-021 MEM: ALUSrc=1, op=010, MemRead=1 (lw) or MemWrite=1 (sw) held every MEM cycle until mem_rdy sampled high; mem_rdy high in first MEM cycle means single-cycle access.
REQ-022 MEM exit: lw -> WB; sw -> pc_we=1, pc_sel=0, next FETCH.
REQ-023 MEM wait counter: if mem_rdy low for MEM_TMO+1 consecutive MEM cycles -> HALT; mem_rdy high on the final allowed cycle still completes.
REQ-024 WB: RegWrite=1, RegDst=1 for R-type, Mem2Reg=1 for lw, pc_we=1, pc_sel=0; next FETCH.
REQ-025 Latency: j/beq 3 cycles; R/addi 4; sw 4+waits; lw 5+waits.
REQ-026 instr_cnt SHALL increment by 1 on every cycle pc_we=1, wrapping modulo 2^CNT_W.
REQ-027 HALT: all controls 0, pc_we=0, halted=1, counter frozen; exits only via rst.
REQ-028 mem_rdy outside MEM SHALL be ignored.

Reset
REQ-029 rst sampled high SHALL force next state FETCH, instr_cnt=0, halted=0, wait counter=0, latched opcode/funct=0.
REQ-030 All outputs SHALL read 0 in the cycle after rst, including rst mid-MEM (MemWrite drops at that edge).
REQ-031 rst SHALL take priority over every transition, including HALT entry in the same cycle.

Structure
REQ-032 Opcode/funct constants, ALU op codes, pc_sel encodings and state enum SHALL reside in shared package mips_ctrl_pkg.
REQ-033 funct-to-op decode SHALL be sub-module alu_op_decode (combinational); FSM, wait counter and instr_cnt stay in multi_cycle_ctrl.

Verification
REQ-034 add $3,$1,$2 (0x00221820): states F,D,E,W; EXEC op=010 RegDst=1 ALUSrc=0; WB RegWrite=1 pc_we=1; instr_cnt 0->1.
REQ-035 beq with zero=1 then zero=0: pc_we in EXEC with pc_sel=1 then 0; no RegWrite; 3 cycles each.
REQ-036 lw with mem_rdy low 3 cycles then high: MemRead high 4 MEM cycles, then WB Mem2Reg=1 RegWrite=1; total 8 cycles.
REQ-037 sw with mem_rdy held low: HALT after 16 MEM cycles, halted=1, MemWrite=0; rst -> FETCH, halted=0.
REQ-038 opcode 0x3F or R funct 0x00: HALT from DECODE, instr_cnt unchanged; rst asserted mid-MEM of a lw: next cycle all outputs 0, state FETCH.
REQ-039 instr_cnt preloaded to 2^CNT_W-1 via 65535 retired j instructions, one more j -> instr_cnt=0.
